// File: rtl/mem_model_pipelined_if.sv
// Request/response bus for mem_model_pipelined: a valid/ready request channel
// and a valid/ready read-response channel.
interface mem_model_pipelined_if #(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned DATA_WIDTH = 32
);
    logic                    req_valid;
    logic                    req_ready;
    logic                    req_we;
    logic [ADDR_WIDTH-1:0]   req_addr;
    logic [DATA_WIDTH-1:0]   req_wdata;
    logic [DATA_WIDTH/8-1:0] req_be;
    logic                    rsp_valid;
    logic                    rsp_ready;
    logic [DATA_WIDTH-1:0]   rsp_data;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
        input  req_ready, rsp_valid, rsp_data
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
        output req_ready, rsp_valid, rsp_data
    );
endinterface

// File: rtl/mem_model_pipelined.sv
// Single-port memory model with self-initialisation, byte-enable writes,
// fixed read latency and a credit-limited fall-through response buffer.
module mem_model_pipelined #(
    parameter int unsigned           ADDR_WIDTH = 8,
    parameter int unsigned           DATA_WIDTH = 32,
    parameter int unsigned           RD_LATENCY = 2,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    mem_model_pipelined_if.slave  bus,
    output logic                  init_done
);
    localparam int unsigned DEPTH     = 1 << ADDR_WIDTH;
    localparam int unsigned NBYTES    = DATA_WIDTH / 8;
    localparam int unsigned BUF_DEPTH = RD_LATENCY + 1;
    localparam int unsigned PW        = $clog2(BUF_DEPTH);
    localparam int unsigned CW        = $clog2(BUF_DEPTH + 1);
    localparam logic [CW-1:0] CREDITS   = CW'(BUF_DEPTH);
    localparam logic [PW-1:0] LAST_SLOT = PW'(BUF_DEPTH - 1);

    typedef enum logic {INIT, RUN} state_e;

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   ptr_q, ptr_d;
    logic [CW-1:0]           out_q, out_d;
    logic [DATA_WIDTH-1:0]   mem_q [DEPTH];
    logic [RD_LATENCY-1:0]   pv_q;
    logic [DATA_WIDTH-1:0]   pd_q [RD_LATENCY];
    logic [DATA_WIDTH-1:0]   buf_q [BUF_DEPTH];
    logic [PW-1:0]           wp_q, wp_d, rp_q, rp_d;
    logic [CW-1:0]           cnt_q, cnt_d;

    logic accept, wr_acc, rd_acc;
    logic pipe_v, buf_empty, push, pop, rsp_fire;
    logic [DATA_WIDTH-1:0] pipe_d;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        if (state_q == INIT) begin
            ptr_d = ptr_q + 1'b1;
            if (ptr_q == '1) state_d = RUN;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= INIT;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    assign init_done     = (state_q == RUN);
    assign bus.req_ready = (state_q == RUN) && (out_q < CREDITS);
    assign accept        = bus.req_valid && bus.req_ready;
    assign wr_acc        = accept && bus.req_we;
    assign rd_acc        = accept && !bus.req_we;

    always_ff @(posedge clk) begin
        if (state_q == INIT) begin
            mem_q[ptr_q] <= INIT_VALUE;
        end else if (wr_acc) begin
            for (int unsigned i = 0; i < NBYTES; i++) begin
                if (bus.req_be[i]) mem_q[bus.req_addr][8*i +: 8] <= bus.req_wdata[8*i +: 8];
            end
        end
    end

    // Read pipeline: stage k holds a read accepted k+1 cycles ago.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pv_q <= '0;
        end else begin
            pv_q[0] <= rd_acc;
            for (int unsigned k = 1; k < RD_LATENCY; k++) pv_q[k] <= pv_q[k-1];
        end
    end

    always_ff @(posedge clk) begin
        pd_q[0] <= mem_q[bus.req_addr];
        for (int unsigned k = 1; k < RD_LATENCY; k++) pd_q[k] <= pd_q[k-1];
    end

    assign pipe_v    = pv_q[RD_LATENCY-1];
    assign pipe_d    = pd_q[RD_LATENCY-1];
    assign buf_empty = (cnt_q == '0);

    // Pipeline output bypasses an empty buffer; it is stored only if not taken now.
    assign bus.rsp_valid = pipe_v || !buf_empty;
    assign bus.rsp_data  = !buf_empty ? buf_q[rp_q] : (pipe_v ? pipe_d : '0);
    assign rsp_fire      = bus.rsp_valid && bus.rsp_ready;
    assign pop           = !buf_empty && bus.rsp_ready;
    assign push          = pipe_v && !(buf_empty && bus.rsp_ready);

    always_comb begin
        wp_d  = wp_q;
        rp_d  = rp_q;
        cnt_d = cnt_q;
        out_d = out_q;
        if (push) wp_d = (wp_q == LAST_SLOT) ? '0 : wp_q + 1'b1;
        if (pop)  rp_d = (rp_q == LAST_SLOT) ? '0 : rp_q + 1'b1;
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
        case ({rd_acc, rsp_fire})
            2'b10:   out_d = out_q + 1'b1;
            2'b01:   out_d = out_q - 1'b1;
            default: out_d = out_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wp_q  <= '0;
            rp_q  <= '0;
            cnt_q <= '0;
            out_q <= '0;
        end else begin
            wp_q  <= wp_d;
            rp_q  <= rp_d;
            cnt_q <= cnt_d;
            out_q <= out_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) buf_q[wp_q] <= pipe_d;
    end
endmodule
